decoder_3_to_8_sequenced: RTL and testbench

//  Buffered, timed 3-to-8 decoder: accepts 3-bit line codes over a valid/ready handshake,

---
 rtl/decoder_3_to_8_sequenced_pkg.sv | 19 +
 rtl/decoder_code_fifo.sv | 62 ++++++
 rtl/decoder_3_to_8_sequenced.sv | 137 +++++++++++++
 tb/tb_decoder_3_to_8_sequenced.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_3_to_8_sequenced_pkg.sv
// Shared definitions for the sequenced 3-to-8 decoder and its benches.
//   LINES        : number of decoded output lines in the standard build
//   dec_state_t  : output sequencer states (IDLE / DRIVE / GAP)
//   cnt_width()  : bits needed for a down-counter holding values 0..max_val
package decoder_3_to_8_sequenced_pkg;

  localparam int unsigned LINES = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } dec_state_t;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/decoder_code_fifo.sv
// Synchronous code FIFO with asynchronous active-high reset.
//   clk, rst           : clock, async active-high reset (flushes pointers/count)
//   push, push_data    : write request and data (ignored when full)
//   pop                : read request (ignored when empty)
//   pop_data           : head entry, valid whenever empty is low
//   full, empty, count : occupancy status, all derived from registered count
module decoder_code_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 3,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/decoder_3_to_8_sequenced.sv
// Buffered, timed 3-to-8 decoder. Codes arrive over valid/ready, are queued,
// and each drives one output line high for HOLD_CYCLES cycles followed by
// GAP_CYCLES all-zero cycles.
//   clk, rst  : clock, async active-high reset
//   in_valid  : in_code valid this cycle
//   in_ready  : a code can be accepted this cycle (low during reset)
//   in_code   : line index to decode
//   out_lines : registered one-hot output, zero when not driving
//   out_valid : high exactly while out_lines is non-zero
//   busy      : sequencer active or codes still queued
module decoder_3_to_8_sequenced
  import decoder_3_to_8_sequenced_pkg::*;
#(
  parameter  int unsigned CODE_W      = 3,
  parameter  int unsigned FIFO_DEPTH  = 4,
  parameter  int unsigned HOLD_CYCLES = 4,
  parameter  int unsigned GAP_CYCLES  = 1,
  localparam int unsigned NUM_LINES   = 2 ** CODE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CODE_W-1:0]    in_code,
  output logic [NUM_LINES-1:0] out_lines,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
  localparam int unsigned FQ_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  dec_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_LINES-1:0] lines_q, lines_d;
  logic                 ready_en;
  logic                 push;
  logic                 pop;
  logic                 load_next;
  logic [CODE_W-1:0]    head_code;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FQ_W-1:0]      fifo_count;

  decoder_code_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_code_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_code),
    .pop       (pop),
    .pop_data  (head_code),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ready_en keeps in_ready low through reset and the cycle it is released,
  // without a combinational path from rst to the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

  assign in_ready  = ready_en & ~fifo_full;
  assign push      = in_valid & in_ready;
  assign out_lines = lines_q;
  assign out_valid = (state_q == ST_DRIVE);
  assign busy      = (state_q != ST_IDLE) | (fifo_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
    end
  end

  // Every "pulse finished" exit funnels through load_next so IDLE, GAP end
  // and gapless DRIVE end share one pop-or-idle decision.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lines_d   = lines_q;
    pop       = 1'b0;
    load_next = 1'b0;

    unique case (state_q)
      ST_IDLE: load_next = 1'b1;
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          if (GAP_CYCLES == 0) begin
            load_next = 1'b1;
          end else begin
            lines_d = '0;
            cnt_d   = GAP_LOAD;
            state_d = ST_GAP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) load_next = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        lines_d = '0;
      end
    endcase

    if (load_next) begin
      if (!fifo_empty) begin
        pop     = 1'b1;
        lines_d = NUM_LINES'(1) << head_code;
        cnt_d   = HOLD_LOAD;
        state_d = ST_DRIVE;
      end else begin
        lines_d = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_decoder_3_to_8_sequenced.sv
// Bench for decoder_3_to_8_sequenced: a timeline model schedules each
// accepted code's pulse arithmetically and predicts outputs every cycle.
module tb_decoder_3_to_8_sequenced;
  import decoder_3_to_8_sequenced_pkg::*;

  localparam int HOLD  = 4;
  localparam int GAP   = 1;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [2:0] in_code;
  logic [7:0] out_lines;
  logic       out_valid, busy;

  logic       f_in_valid, f_in_ready;
  logic [2:0] f_in_code;
  logic [7:0] f_out_lines;
  logic       f_out_valid, f_busy;

  always #5 clk = ~clk;

  decoder_3_to_8_sequenced #(
    .CODE_W(3), .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)
  ) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_lines(out_lines), .out_valid(out_valid), .busy(busy)
  );

  decoder_3_to_8_sequenced #(
    .CODE_W(3), .FIFO_DEPTH(4), .HOLD_CYCLES(1), .GAP_CYCLES(0)
  ) u_dut_fast (
    .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .in_code(f_in_code), .out_lines(f_out_lines), .out_valid(f_out_valid), .busy(f_busy)
  );

  typedef struct {
    int code;
    int n;
    int s;
  } pulse_t;

  pulse_t pq[$];
  int     last_s;
  bit     m_ready_en;
  bit     m_ready;
  bit     acc_now;
  int     acc_cyc;
  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void model_reset();
    pq.delete();
    last_s     = -1000;
    m_ready_en = 1'b0;
    m_ready    = 1'b0;
  endfunction

  // Pulse of a code accepted at edge n starts at the later of n+1 and the
  // previous start plus HOLD+GAP; it is seen after edges s..s+HOLD-1.
  task automatic check_outputs();
    logic [7:0] exp_lines;
    int         queued;
    while (pq.size() != 0 && pq[0].s + HOLD + GAP <= cyc) void'(pq.pop_front());
    exp_lines = '0;
    queued    = 0;
    foreach (pq[i]) begin
      if (pq[i].s <= cyc && cyc < pq[i].s + HOLD) exp_lines = 8'(1 << pq[i].code);
      if (pq[i].s > cyc) queued++;
    end
    m_ready = m_ready_en && (queued < DEPTH);
    check_val("out_lines", out_lines, exp_lines);
    check_val("out_valid", out_valid, exp_lines != 0);
    check_val("busy", busy, pq.size() != 0);
    check_val("in_ready", in_ready, m_ready);
    check_val("onehot", ($countones(out_lines) <= 1), 1);
  endtask

  task automatic step();
    pulse_t p;
    acc_now = 1'b0;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      if (in_valid && m_ready) begin
        p.code  = int'(in_code);
        p.n     = cyc;
        p.s     = imax(cyc + 1, last_s + HOLD + GAP);
        last_s  = p.s;
        pq.push_back(p);
        acc_now = 1'b1;
        acc_cyc = cyc;
      end
      m_ready_en = 1'b1;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_code(input logic [2:0] c);
    in_valid = 1'b1;
    in_code  = c;
    for (int g = 0; g < 100; g++) begin
      step();
      if (acc_now) break;
    end
    check_val("accept_timeout", acc_now, 1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int g = 0; g < 200 && pq.size() != 0; g++) step();
    step();
    check_val("drain_busy", busy, 0);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_code    = '0;
    f_in_valid = 1'b0;
    f_in_code  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_lines", out_lines, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    step();
    check_val("ready_after_release", in_ready, 1);

    // Single code 5: visible after edges N+1..N+4, zero at N+5, idle at N+6.
    send_code(3'b101);
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (cyc == acc_cyc + 1) check_val("single_first", out_lines, 8'h20);
      if (cyc == acc_cyc + 4) check_val("single_last", out_lines, 8'h20);
      if (cyc == acc_cyc + 5) check_val("single_gap", out_lines, 8'h00);
      if (cyc == acc_cyc + 6) check_val("single_idle", busy, 0);
    end

    // Walk all codes back-to-back.
    for (int c = 0; c < 8; c++) send_code(3'(c));
    drain();

    // Six codes with valid held: FIFO fills, in_ready drops, nothing lost.
    for (int c = 0; c < 6; c++) send_code(3'($urandom_range(0, 7)));
    drain();

    // Gapless single-cycle build: 2 then 6 in consecutive cycles.
    check_val("fast_ready", f_in_ready, 1);
    f_in_valid = 1'b1;
    f_in_code  = 3'd2;
    step();
    f_in_code  = 3'd6;
    step();
    check_val("fast_first", f_out_lines, 8'h04);
    check_val("fast_valid", f_out_valid, 1);
    f_in_valid = 1'b0;
    step();
    check_val("fast_second", f_out_lines, 8'h40);
    step();
    check_val("fast_done", f_out_lines, 8'h00);
    check_val("fast_idle", f_busy, 0);

    // Randomized traffic; sender holds each code until accepted.
    for (int k = 0; k < 400; k++) begin
      if (!in_valid || acc_now) begin
        if ($urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          in_code  = 3'($urandom_range(0, 7));
        end else begin
          in_valid = 1'b0;
        end
      end
      step();
    end
    drain();

    // Reset mid-DRIVE of code 3 with two codes queued.
    send_code(3'd3);
    send_code(3'($urandom_range(0, 7)));
    send_code(3'($urandom_range(0, 7)));
    in_valid = 1'b0;
    check_val("pre_rst_drive", out_lines, 8'h08);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_lines", out_lines, 0);
    check_val("mid_rst_valid", out_valid, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_ready", in_ready, 0);
    model_reset();
    step();
    step();
    rst = 1'b0;
    step();
    check_val("post_rst_ready", in_ready, 1);
    for (int k = 0; k < 10; k++) begin
      step();
      check_val("post_rst_quiet", out_lines, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
